instr_fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the main decoder/control unit. Owns the program counter and issues word fetches to instruction memory over a req/ack handshake. Holds the returned instruction in an output register until the decode stage accepts it. Applies taken-branch redirects, squashes stale in-flight fetches, and flags misaligned targets and memory timeouts.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/instr_fetch_unit_if.sv | 35 +++
 rtl/fetch_wdog.sv | 26 ++
 rtl/instr_fetch_unit.sv | 105 ++++++++++
 tb/tb_instr_fetch_unit.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants, also consumed by the control unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ    = 2'd0,
    WAIT   = 2'd1,
    SQUASH = 2'd2,
    FULL   = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Base-ISA major opcodes decoded by the control unit from instr[6:0].
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory handshake, redirect input and decode-side hand-off.
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] instr;
  logic [6:0]      instr_opcode;
  logic [XLEN-1:0] instr_pc;
  logic            instr_valid;
  logic            id_ready;
  logic            fetch_err;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  branch_taken, branch_target,
    output instr, instr_opcode, instr_pc, instr_valid,
    input  id_ready,
    output fetch_err
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output branch_taken, branch_target,
    input  instr, instr_opcode, instr_pc, instr_valid,
    output id_ready,
    input  fetch_err
  );
endinterface

// File: rtl/fetch_wdog.sv
// Saturating wait counter; expire flags the cycle whose increment reaches TIMEOUT (and every cycle after).
module fetch_wdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  logic [7:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && (count_reg != LIMIT)) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  assign expire = en && !clr && (count_reg >= (LIMIT - 8'd1));
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches one word at a time and holds it until decode accepts.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  bus
);
  fetch_state_t    state_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] req_addr_reg;
  logic [XLEN-1:0] instr_reg;
  logic [XLEN-1:0] instr_pc_reg;
  logic            instr_valid_reg;
  logic            fetch_err_reg;

  logic [XLEN-1:0] target_aligned;
  logic            misaligned;
  logic            waiting;
  logic            wdog_expire;

  assign target_aligned = {bus.branch_target[XLEN-1:2], 2'b00};
  assign misaligned     = bus.branch_taken && (bus.branch_target[1:0] != 2'b00);
  assign waiting        = (state_reg == WAIT) || (state_reg == SQUASH);

  fetch_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (bus.imem_ack || !waiting),
    .en     (waiting),
    .expire (wdog_expire)
  );

  // req_addr always equals pc on entry to REQ, so imem_addr never needs a pc/req_addr mux.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= REQ;
      pc_reg          <= RESET_PC;
      req_addr_reg    <= RESET_PC;
      instr_reg       <= XLEN'(NOP_INSTR);
      instr_pc_reg    <= '0;
      instr_valid_reg <= 1'b0;
      fetch_err_reg   <= 1'b0;
    end else begin
      if (wdog_expire || misaligned) begin
        fetch_err_reg <= 1'b1;
      end
      case (state_reg)
        REQ, WAIT: begin
          if (bus.branch_taken) begin
            pc_reg <= target_aligned;
            if (bus.imem_ack) begin
              req_addr_reg <= target_aligned;
              state_reg    <= REQ;
            end else begin
              state_reg    <= SQUASH;
            end
          end else if (bus.imem_ack) begin
            instr_reg       <= bus.imem_rdata;
            instr_pc_reg    <= req_addr_reg;
            instr_valid_reg <= 1'b1;
            pc_reg          <= req_addr_reg + XLEN'(4);
            state_reg       <= FULL;
          end else begin
            state_reg <= WAIT;
          end
        end
        SQUASH: begin
          if (bus.branch_taken) begin
            pc_reg <= target_aligned;
          end
          if (bus.imem_ack) begin
            req_addr_reg <= bus.branch_taken ? target_aligned : pc_reg;
            state_reg    <= REQ;
          end
        end
        FULL: begin
          if (bus.branch_taken) begin
            instr_valid_reg <= 1'b0;
            pc_reg          <= target_aligned;
            req_addr_reg    <= target_aligned;
            state_reg       <= REQ;
          end else if (bus.id_ready) begin
            instr_valid_reg <= 1'b0;
            req_addr_reg    <= pc_reg;
            state_reg       <= REQ;
          end
        end
        default: state_reg <= REQ;
      endcase
    end
  end

  assign bus.imem_req     = (state_reg != FULL) && !reset;
  assign bus.imem_addr    = req_addr_reg;
  assign bus.instr        = instr_reg;
  assign bus.instr_opcode = instr_reg[6:0];
  assign bus.instr_pc     = instr_pc_reg;
  assign bus.instr_valid  = instr_valid_reg;
  assign bus.fetch_err    = fetch_err_reg;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a transaction-level reference model checked every cycle.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int TO = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset2 = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.XLEN(32)) bus ();
  instr_fetch_unit_if #(.XLEN(32)) bus2 ();

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .TIMEOUT(TO)) dut2 (
    .clk(clk), .reset(reset2), .bus(bus2)
  );

  int n_pass = 0;
  int n_total = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic void fail_timeout(input string name);
    n_total++;
    $display("FAIL %s: got no event, required event within budget (t=%0t)", name, $time);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [6:0] opc;
    case (a[4:2])
      3'd0: opc = OPC_LOAD;
      3'd1: opc = OPC_OP;
      3'd2: opc = OPC_BRANCH;
      3'd3: opc = OPC_OP_IMM;
      3'd4: opc = OPC_STORE;
      3'd5: opc = OPC_JAL;
      3'd6: opc = OPC_LUI;
      default: opc = OPC_AUIPC;
    endcase
    return {a[26:2], opc};
  endfunction

  // Memory responder: ack after `lat` cycles of a held request (0 = same cycle).
  int lat = 0;
  bit no_ack = 1'b0;
  int cnt = 0;
  assign bus.imem_ack   = bus.imem_req && !no_ack && (cnt >= lat);
  assign bus.imem_rdata = mem_word(bus.imem_addr);
  always @(posedge clk) cnt <= (bus.imem_req && !bus.imem_ack) ? cnt + 1 : 0;

  assign bus2.imem_ack      = bus2.imem_req;
  assign bus2.imem_rdata    = mem_word(bus2.imem_addr);
  assign bus2.id_ready      = 1'b1;
  assign bus2.branch_taken  = 1'b0;
  assign bus2.branch_target = 32'h0;

  logic [31:0] dq[$];
  logic [31:0] q2[$];

  // Reference model, transaction view: one outstanding fetch or one held word.
  logic        m_out, m_held, m_discard, m_err;
  logic [31:0] m_addr, m_next, m_instr, m_ipc;
  int          m_age;

  initial begin
    logic [31:0] tgt;
    forever begin
      @(negedge clk);
      if (!reset2 && bus2.imem_req && bus2.imem_ack) q2.push_back(bus2.imem_addr);
      if (reset) begin
        m_out = 1'b1; m_held = 1'b0; m_discard = 1'b0; m_err = 1'b0;
        m_addr = 32'h0; m_next = 32'h0; m_instr = 32'h13; m_ipc = 32'h0; m_age = 0;
        check("rst_req", 32'(bus.imem_req), 32'h0);
        check("rst_valid", 32'(bus.instr_valid), 32'h0);
        check("rst_instr", bus.instr, 32'h13);
        check("rst_err", 32'(bus.fetch_err), 32'h0);
      end else begin
        check("imem_req", 32'(bus.imem_req), 32'(m_out));
        if (m_out) check("imem_addr", bus.imem_addr, m_addr);
        check("instr_valid", 32'(bus.instr_valid), 32'(m_held));
        check("instr", bus.instr, m_instr);
        check("instr_opcode", 32'(bus.instr_opcode), 32'(m_instr[6:0]));
        check("instr_pc", bus.instr_pc, m_ipc);
        check("fetch_err", 32'(bus.fetch_err), 32'(m_err));
        if (bus.instr_valid && bus.id_ready && !bus.branch_taken) dq.push_back(bus.instr_pc);

        tgt = bus.branch_target & ~32'd3;
        if (bus.branch_taken && (bus.branch_target[1:0] != 2'b00)) m_err = 1'b1;
        if (m_out) begin
          if (bus.branch_taken) m_next = tgt;
          if (bus.imem_ack) begin
            m_age = 0;
            if (bus.branch_taken || m_discard) begin
              m_discard = 1'b0;
              m_addr = m_next;
            end else begin
              m_held = 1'b1; m_out = 1'b0;
              m_instr = bus.imem_rdata; m_ipc = m_addr;
              m_next = m_addr + 32'd4;
            end
          end else begin
            m_age++;
            if (m_age > TO) m_err = 1'b1;
            if (bus.branch_taken) m_discard = 1'b1;
          end
        end else if (bus.branch_taken || bus.id_ready) begin
          if (bus.branch_taken) m_next = tgt;
          m_held = 1'b0; m_out = 1'b1; m_addr = m_next; m_age = 0;
        end
      end
    end
  end

  task automatic do_reset(input int l, input bit na, input logic rdy);
    @(posedge clk); #1;
    reset = 1'b1; bus.branch_taken = 1'b0; bus.id_ready = rdy; lat = l; no_ack = na;
    dq.delete();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic wait_dq(input int n, input int budget, input string name);
    int k = 0;
    while (dq.size() < n && k < budget) begin @(negedge clk); k++; end
    if (dq.size() < n) fail_timeout(name);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int k = 0;
    do begin @(negedge clk); k++; end while (!bus.instr_valid && k < budget);
    if (!bus.instr_valid) fail_timeout(name);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [31:0] held;
    int k;
    bus.branch_taken = 1'b0; bus.branch_target = 32'h0; bus.id_ready = 1'b0;
    @(negedge clk);
    check("rst_opcode", 32'(bus.instr_opcode), 32'h13);
    @(posedge clk); #1 reset2 = 1'b0;

    // Zero-wait stream 0x0, 0x4, 0x8
    do_reset(0, 1'b0, 1'b1);
    wait_dq(3, 40, "t1_deliver");
    if (dq.size() >= 3) begin
      check("t1_pc0", dq[0], 32'h0); check("t1_pc1", dq[1], 32'h4); check("t1_pc2", dq[2], 32'h8);
    end
    $display("t1 zero-wait stream done");

    // 3-cycle memory, decode stalled 4 cycles
    do_reset(3, 1'b0, 1'b0);
    wait_valid(20, "t2_valid");
    check("t2_instr", bus.instr, 32'h0000_0003);
    check("t2_opcode", 32'(bus.instr_opcode), 32'h03);
    held = bus.instr;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_hold_instr", bus.instr, held);
      check("t2_hold_noreq", 32'(bus.imem_req), 32'h0);
    end
    @(posedge clk); #1 bus.id_ready = 1'b1;
    @(posedge clk); #1 bus.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_req", 32'(bus.imem_req), 32'h1);
      check("t2_addr", bus.imem_addr, 32'h4);
    end
    $display("t2 stalled decode done");

    // Redirect while waiting on 0x8
    do_reset(4, 1'b0, 1'b1);
    k = 0;
    do begin @(negedge clk); k++; end while (!(bus.imem_req && bus.imem_addr == 32'h8) && k < 40);
    if (!(bus.imem_req && bus.imem_addr == 32'h8)) fail_timeout("t3_reach8");
    @(posedge clk); #1 bus.branch_taken = 1'b1; bus.branch_target = 32'h100;
    @(posedge clk); #1 bus.branch_taken = 1'b0;
    @(negedge clk);
    check("t3_squash_addr", bus.imem_addr, 32'h8);
    check("t3_squash_req", 32'(bus.imem_req), 32'h1);
    wait_dq(3, 60, "t3_deliver");
    if (dq.size() >= 3) begin
      check("t3_pc1", dq[1], 32'h4); check("t3_pc2", dq[2], 32'h100);
    end
    $display("t3 redirect in WAIT done");

    // Misaligned redirect in FULL with id_ready
    do_reset(0, 1'b0, 1'b0);
    wait_valid(20, "t4_valid");
    @(posedge clk); #1 bus.id_ready = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h102;
    @(posedge clk); #1 bus.id_ready = 1'b0; bus.branch_taken = 1'b0;
    @(negedge clk);
    check("t4_addr", bus.imem_addr, 32'h100);
    check("t4_err", 32'(bus.fetch_err), 32'h1);
    check("t4_dropped", 32'(dq.size()), 32'h0);
    $display("t4 misaligned redirect done");

    // Timeout: no ack
    do_reset(0, 1'b1, 1'b1);
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      if (c == 15) check("t5_err_before", 32'(bus.fetch_err), 32'h0);
      if (c == 16) begin
        check("t5_err_after", 32'(bus.fetch_err), 32'h1);
        check("t5_req_held", 32'(bus.imem_req), 32'h1);
      end
    end
    @(posedge clk); #1 no_ack = 1'b0;
    wait_dq(1, 10, "t5_deliver");
    if (dq.size() >= 1) check("t5_pc0", dq[0], 32'h0);
    check("t5_err_sticky", 32'(bus.fetch_err), 32'h1);
    $display("t5 timeout done");

    // Reset mid-WAIT
    do_reset(10, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("t6_req_in_reset", 32'(bus.imem_req), 32'h0);
    check("t6_err_cleared", 32'(bus.fetch_err), 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("t6_restart_req", 32'(bus.imem_req), 32'h1);
    check("t6_restart_addr", bus.imem_addr, 32'h0);
    wait_dq(1, 30, "t6_deliver");
    $display("t6 reset mid-wait done");

    // Wrap-around instance
    if (q2.size() >= 3) begin
      check("wrap_first", q2[0], 32'hFFFF_FFFC);
      check("wrap_second", q2[1], 32'h0);
      check("wrap_third", q2[2], 32'h4);
    end else fail_timeout("wrap_fetches");
    check("wrap_no_err", 32'(bus2.fetch_err), 32'h0);
    $display("wrap instance done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
